// File: rtl/mandelbrot_pipe.sv
// Mandelbrot escape-count pipeline: map stage, ITER unrolled iterate stages, output register.
// One pixel per cycle; a stalled output freezes every stage, so in_ready = !out_valid || out_ready.
module mandelbrot_pipe #(
  parameter int RESX = 32,
  parameter int RESY = 32,
  parameter int CW   = 11,
  parameter int DW   = 32,
  parameter int ITER = 16,
  localparam int VW  = $clog2(ITER + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] xin,
  input  logic [CW-1:0] yin,
  input  logic          in_last,
  input  logic [DW-1:0] cfg_x0,
  input  logic [DW-1:0] cfg_y0,
  input  logic [DW-1:0] cfg_step,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] xout,
  output logic [CW-1:0] yout,
  output logic [VW-1:0] v,
  output logic          out_last
);

  localparam int FRAC = DW - 4;
  // 4.0 at the 2*FRAC scale of a full product, one bit wider than a product
  localparam logic signed [2*DW:0] MAG4 = {{(2*DW-2*FRAC-2){1'b0}}, 1'b1, {(2*FRAC+2){1'b0}}};

  if (RESX > (1 << CW) || RESY > (1 << CW)) begin : g_bad_res
    $error("mandelbrot_pipe: RESX/RESY do not fit in CW coordinate bits");
  end

  typedef struct packed {
    logic          vld;
    logic [DW-1:0] cr;
    logic [DW-1:0] ci;
    logic [DW-1:0] zr;
    logic [DW-1:0] zi;
    logic [VW-1:0] cnt;
    logic          esc;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          last;
  } stage_t;

  function automatic stage_t iterate(input stage_t s);
    logic signed [2*DW-1:0] rr;
    logic signed [2*DW-1:0] ii;
    logic signed [2*DW-1:0] ri;
    logic signed [2*DW:0]   mag;
    stage_t                 o;
    o   = s;
    rr  = $signed(s.zr) * $signed(s.zr);
    ii  = $signed(s.zi) * $signed(s.zi);
    ri  = $signed(s.zr) * $signed(s.zi);
    mag = rr + ii;
    if (!s.esc) begin
      if (mag > MAG4) begin
        o.esc = 1'b1;
      end else begin
        o.zr  = DW'(rr >>> FRAC) - DW'(ii >>> FRAC) + s.cr;
        o.zi  = DW'((ri <<< 1) >>> FRAC) + s.ci;
        o.cnt = s.cnt + VW'(1);
      end
    end
    return o;
  endfunction

  stage_t st [0:ITER];
  stage_t map_s;
  logic   adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    map_s      = '0;
    map_s.vld  = in_valid;
    map_s.cr   = cfg_x0 + ({{(DW-CW){1'b0}}, xin} * cfg_step);
    map_s.ci   = cfg_y0 + ({{(DW-CW){1'b0}}, yin} * cfg_step);
    map_s.x    = xin;
    map_s.y    = yin;
    map_s.last = in_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= ITER; k++) st[k] <= '0;
      out_valid <= 1'b0;
      xout      <= '0;
      yout      <= '0;
      v         <= '0;
      out_last  <= 1'b0;
    end else if (adv) begin
      st[0] <= map_s;
      for (int k = 1; k <= ITER; k++) st[k] <= iterate(st[k-1]);
      out_valid <= st[ITER].vld;
      xout      <= st[ITER].x;
      yout      <= st[ITER].y;
      v         <= st[ITER].cnt;
      out_last  <= st[ITER].last;
    end
  end

endmodule

// File: tb/tb_mandelbrot_pipe.sv
// Bench for mandelbrot_pipe: escape-count reference model with an in-order expectation queue.
module tb_mandelbrot_pipe;
  localparam int ITER = 16;
  localparam int CW   = 11;
  localparam int DW   = 32;
  localparam int VW   = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] xin = '0;
  logic [CW-1:0] yin = '0;
  logic          in_last = 1'b0;
  logic [DW-1:0] cfg_x0 = '0;
  logic [DW-1:0] cfg_y0 = '0;
  logic [DW-1:0] cfg_step = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CW-1:0] xout;
  logic [CW-1:0] yout;
  logic [VW-1:0] v;
  logic          out_last;

  always #5 clk = ~clk;

  mandelbrot_pipe #(.RESX(32), .RESY(32), .CW(CW), .DW(DW), .ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .xin(xin), .yin(yin), .in_last(in_last),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_step(cfg_step),
    .out_valid(out_valid), .out_ready(out_ready),
    .xout(xout), .yout(yout), .v(v), .out_last(out_last)
  );

  typedef struct {
    int unsigned x;
    int unsigned y;
    int unsigned v;
    bit          last;
  } pix_t;

  pix_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          armed = 0;
  bit          rand_ready = 0;
  int          out_count = 0;
  int          last_count = 0;
  bit          held_vld = 0;
  logic [28:0] held = '0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint wrap32(input longint a);
    int t;
    t = int'(a);
    return longint'(t);
  endfunction

  // Escape-time loop in Q4.28: count updates until |z|^2 exceeds 4.0, capped at ITER.
  function automatic int model_v(input longint cr, input longint ci);
    longint zr = 0;
    longint zi = 0;
    longint rr, ii, p, nzr;
    longint four = 64'sd1 <<< 58;
    int     n = 0;
    for (int k = 0; k < ITER; k++) begin
      rr = zr * zr;
      ii = zi * zi;
      if (rr > four - ii) break;
      p   = zr * zi;
      nzr = wrap32((rr >>> 28) - (ii >>> 28) + cr);
      zi  = wrap32(((p * 2) >>> 28) + ci);
      zr  = nzr;
      n++;
    end
    return n;
  endfunction

  function automatic logic [28:0] pk(input pix_t e);
    logic [28:0] t;
    t = {1'b1, e.x[10:0], e.y[10:0], e.v[4:0], e.last};
    return t;
  endfunction

  always @(negedge clk) begin
    logic [28:0] cur;
    pix_t        e;
    longint      cr, ci;
    if (armed) begin
      if (!rst_n) begin
        exp_q.delete();
        held_vld = 0;
      end else begin
        cur = {out_valid, xout, yout, v, out_last};
        if (out_ready) check("in_ready_when_out_ready", longint'(in_ready), 1);
        if (held_vld) check("stall_hold", longint'(cur), longint'(held));
        if (out_valid && !out_ready) begin
          held_vld = 1;
          held = cur;
        end else begin
          held_vld = 0;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", longint'(out_valid), 0);
          end else begin
            e = exp_q.pop_front();
            check("pixel", longint'(cur), longint'(pk(e)));
            out_count++;
            if (out_last) last_count++;
          end
        end
        if (in_valid && in_ready) begin
          cr = wrap32(longint'($signed(cfg_x0)) + longint'(xin) * longint'($signed(cfg_step)));
          ci = wrap32(longint'($signed(cfg_y0)) + longint'(yin) * longint'($signed(cfg_step)));
          e.x = xin;
          e.y = yin;
          e.v = model_v(cr, ci);
          e.last = in_last;
          exp_q.push_back(e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? ($urandom_range(1, 0) != 0) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Latency counts the presenting cycle as cycle 0, so out_valid is first seen in cycle ITER+2.
  task automatic latency_run(input string nm, input logic [DW-1:0] x0, input int exp_v);
    int cyc;
    @(posedge clk);
    #1;
    cfg_x0 = x0; cfg_y0 = '0; cfg_step = '0;
    xin = '0; yin = '0; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({nm, "_latency"}, cyc, ITER + 2);
    check({nm, "_v"}, longint'(v), exp_v);
  endtask

  task automatic send(input int x, input int y, input bit last);
    bit acc;
    acc = 0;
    while (!acc) begin
      cfg_step = $urandom_range(32'h0080_0000, 0);
      cfg_x0   = 32'h0 - $urandom_range(32'h2000_0000, 0);
      cfg_y0   = 32'h0 - $urandom_range(32'h1800_0000, 0);
      xin = CW'(x); yin = CW'(y); in_last = last; in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(nm, exp_q.size(), 0);
  endtask

  initial begin
    int seen;
    check("model_zero", model_v(0, 0), 16);
    check("model_one", model_v(64'sh1000_0000, 0), 3);
    check("model_minus_two", model_v(-64'sh2000_0000, 0), 16);
    check("model_half", model_v(64'sh0800_0000, 0), 5);
    check("model_two", model_v(64'sh2000_0000, 0), 2);
    check("model_i", model_v(0, 64'sh1000_0000), 16);

    @(posedge clk);
    @(posedge clk);
    #7;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_v", longint'(v), 0);
    check("rst_xout", longint'(xout), 0);
    check("rst_yout", longint'(yout), 0);
    check("rst_out_last", longint'(out_last), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    armed = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    latency_run("zero", 32'h0000_0000, 16);
    latency_run("one", 32'h1000_0000, 3);
    latency_run("minus_two", 32'hE000_0000, 16);
    latency_run("half", 32'h0800_0000, 5);
    drain("drain_directed");

    rand_ready = 1;
    out_count = 0;
    last_count = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(2, 0) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
      send($urandom_range(31, 0), $urandom_range(31, 0), i == 39);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    drain("drain_stream");
    check("stream_count", out_count, 40);
    check("stream_last_count", last_count, 1);
    rand_ready = 0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) send(i, 9 - i, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("flushed_out_valid_cycles", seen, 0);
    latency_run("post_reset", 32'h0000_0000, 16);
    drain("drain_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mandelbrot_pipe.md
MANDELBROT_PIPE -- requirements
Module: mandelbrot_pipe

Interface
REQ-001 Parameter RESX, default 32, horizontal resolution; the xin range is 0..RESX-1.
REQ-002 Parameter RESY, default 32, vertical resolution; the yin range is 0..RESY-1.
REQ-003 Parameter CW, default 11, coordinate width.
REQ-004 Parameter DW, default 32, signed fixed-point data width: 4 integer bits including sign, FRAC=DW-4 fraction bits.
REQ-005 Parameter ITER, default 16, maximum iteration count, equal to the number of iteration stages; VW=$clog2(ITER+1).
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 in_valid  in  1  the input pixel is offered.
REQ-009 in_ready  out  1  the block accepts the pixel this cycle.
REQ-010 xin, yin  in  CW each  pixel coordinates.
REQ-011 in_last  in  1  sideband end-of-frame flag, carried with the pixel.
REQ-012 cfg_x0, cfg_y0  in  DW  signed complex-plane origin.
REQ-013 cfg_step  in  DW  signed per-pixel step.
REQ-014 out_valid  out  1  the output pixel is valid.
REQ-015 out_ready  in  1  the downstream accepts the output pixel.
REQ-016 xout, yout  out  CW each  coordinates of the output pixel.
REQ-017 v  out  VW  escape iteration count.
REQ-018 out_last  out  1  in_last of the output pixel.

Function
REQ-019 A transfer SHALL occur on a rising edge when valid and ready are both high; this holds on both ports.
REQ-020 The pipeline SHALL be ITER+2 registers deep: stage 0 (map), stages 1..ITER (iterate), and the output register; each register carries a valid bit.
REQ-021 Global advance: adv = !out_valid || out_ready. Every stage SHALL shift only when adv is high and SHALL hold otherwise.
REQ-022 in_ready SHALL equal adv (combinational, no dependence on in_valid).
REQ-023 Stage 0 SHALL compute cr = cfg_x0 + xin*cfg_step and ci = cfg_y0 + yin*cfg_step, with xin and yin zero-extended, wrapping modulo 2^DW. It SHALL also set zr=zi=0, count=0 and esc=0.
REQ-024 cfg_* SHALL be sampled at input acceptance only; changing cfg_* SHALL NOT affect pixels already accepted.
REQ-025 In each iterate stage, when esc=0 and zr^2+zi^2 > 4.0, the stage SHALL set esc=1. The comparison SHALL use the full 2*DW-bit products.
REQ-026 In each iterate stage, when esc=0 and the magnitude test fails, the stage SHALL compute zr' = zr^2 - zi^2 + cr and zi' = 2*zr*zi + ci and SHALL increment count.
REQ-027 In each iterate stage, when esc=1, z and count SHALL pass through unchanged.
REQ-028 Products SHALL be taken at 2*DW bits and then arithmetic-shifted right by FRAC (truncation toward negative infinity); sums SHALL wrap at DW bits.
REQ-029 Pixels with |cr| > 2.0 or |ci| > 2.0 are outside the contract; v is unspecified for them, but the handshake and sideband SHALL remain correct.
REQ-030 v SHALL be the final count, in the range 0..ITER; v=ITER means the pixel did not escape.
REQ-031 xout, yout and out_last SHALL be carried unchanged alongside the pixel.
REQ-032 Latency without stalls SHALL be exactly ITER+2 cycles from the accepting edge to out_valid rising.
REQ-033 Bubbles (in_valid=0 on an adv cycle) SHALL propagate as invalid slots and SHALL never produce out_valid.
REQ-034 Output order SHALL equal acceptance order; no pixel is lost or duplicated under any out_ready pattern.
REQ-035 While out_valid=1 and out_ready=0, xout, yout, v and out_last SHALL be held stable.
REQ-036 A simultaneous output transfer and input acceptance in one cycle SHALL be permitted, giving full throughput of one pixel per cycle.

Reset
REQ-037 On rst_n=0, regardless of clk, all stage valid bits and out_valid SHALL clear, and xout, yout, v and out_last SHALL be 0.
REQ-038 While rst_n=0 the block SHALL hold in_ready=1 (because out_valid=0); no transfer takes effect until the first rising edge after rst_n returns to 1.
REQ-039 Reset asserted mid-operation SHALL discard every in-flight pixel; none of them SHALL appear after reset.

Verification (DW=32, FRAC=28, ITER=16)
REQ-040 Assert rst_n=0 asynchronously between edges. Required: out_valid=0, v=0, xout=yout=0 and in_ready=1 immediately.
REQ-041 Apply cfg_x0=cfg_y0=cfg_step=0 and accept (0,0) with out_ready=1. Required: out_valid rises 18 cycles later with v=16.
REQ-042 Apply cfg_x0=0x10000000 (1.0), cfg_step=0 and accept one pixel. Required: v=3 (z: 0, 1, 2, 5, escape at stage 4).
REQ-043 Apply cfg_x0=0xE0000000 (-2.0), cfg_step=0. Required: v=16 (|z|^2 stays exactly 4, which is not >4).
REQ-044 Stream 40 pixels with in_last on the final one; toggle out_ready pseudo-randomly and insert in_valid gaps. Required: the 40 outputs arrive in order with correct xout/yout, a single out_last on pixel 40, and outputs held stable while stalled.
REQ-045 Accept 10 pixels, then pulse rst_n=0 for one cycle while they are in flight. Required: no out_valid for any of the 10; the next pixel accepted emerges after ITER+2 cycles.
